axis_frame_len_check: RTL

- AXI-Stream frame length policer placed directly upstream of the frame FIFO.
- Counts beats per frame and flags undersize frames by setting tuser on the last beat, so the downstream FIFO discards them.
- Truncates oversize frames at MAX_LEN beats, with tlast and tuser forced high on that beat, then drops the rest of the frame.
- One register stage of latency; full-throughput handshake.

---
 rtl/axis_frame_len_check.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/axis_frame_len_check.sv
// axis_frame_len_check
// AXI-Stream frame length policer that sits directly in front of the frame FIFO.
// Undersize frames get tuser set on their last beat so the FIFO discards them.
// Oversize frames are cut at MAX_LEN beats with tlast/tuser forced high, and the
// remainder of the frame is swallowed.
// Data passes through one register stage at full throughput.
// Optional feature macro: FRAME_LEN_STATS_EN adds saturating 16-bit frame counters.

module axis_frame_len_check #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 12,
    parameter int MIN_LEN    = 64,
    parameter int MAX_LEN    = 1518
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic [DATA_WIDTH-1:0] input_axis_tdata,
    input  logic                  input_axis_tvalid,
    output logic                  input_axis_tready,
    input  logic                  input_axis_tlast,
    input  logic                  input_axis_tuser,

    output logic [DATA_WIDTH-1:0] output_axis_tdata,
    output logic                  output_axis_tvalid,
    input  logic                  output_axis_tready,
    output logic                  output_axis_tlast,
    output logic                  output_axis_tuser,

    output logic                  frame_too_short,
    output logic                  frame_too_long
`ifdef FRAME_LEN_STATS_EN
    ,
    output logic [15:0]           good_frame_count,
    output logic [15:0]           short_frame_count,
    output logic [15:0]           long_frame_count
`endif
);

    typedef enum logic {
        PASS    = 1'b0,
        DISCARD = 1'b1
    } state_t;

    localparam logic [LEN_WIDTH-1:0] MIN_L = LEN_WIDTH'(MIN_LEN);
    localparam logic [LEN_WIDTH-1:0] MAX_L = LEN_WIDTH'(MAX_LEN);

    state_t               state;
    logic [LEN_WIDTH-1:0] count;
    logic [LEN_WIDTH-1:0] n;
    logic                 accept;
    logic                 is_short;
    logic                 is_max;

    // While discarding nothing is loaded, so upstream may always advance;
    // otherwise accept only if the output register is empty or draining.
    assign input_axis_tready = (state == DISCARD) | output_axis_tready | ~output_axis_tvalid;
    assign accept            = input_axis_tvalid & input_axis_tready;

    // Count never exceeds MAX_LEN - 1 before increment, so n cannot wrap.
    assign n        = count + 1'b1;
    assign is_short = (n < MIN_L);
    assign is_max   = (n == MAX_L);

    // Output register, beat counter, policing state and status pulses.
    // NOTE: every register here uses <= so all of them update from the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= PASS;
            count              <= '0;
            output_axis_tdata  <= '0;
            output_axis_tvalid <= 1'b0;
            output_axis_tlast  <= 1'b0;
            output_axis_tuser  <= 1'b0;
            frame_too_short    <= 1'b0;
            frame_too_long     <= 1'b0;
        end else begin
            frame_too_short <= 1'b0;
            frame_too_long  <= 1'b0;

            // Drain; a beat loaded below in the same cycle overrides this.
            if (output_axis_tvalid && output_axis_tready) begin
                output_axis_tvalid <= 1'b0;
            end

            case (state)
                PASS: begin
                    if (accept) begin
                        output_axis_tdata  <= input_axis_tdata;
                        output_axis_tvalid <= 1'b1;
                        if (input_axis_tlast) begin
                            // Upstream tuser only matters on the closing beat.
                            output_axis_tlast <= 1'b1;
                            output_axis_tuser <= input_axis_tuser | is_short;
                            frame_too_short   <= is_short;
                            count             <= '0;
                        end else if (is_max) begin
                            // Truncate: close the frame as bad and drop the rest.
                            output_axis_tlast <= 1'b1;
                            output_axis_tuser <= 1'b1;
                            frame_too_long    <= 1'b1;
                            count             <= '0;
                            state             <= DISCARD;
                        end else begin
                            output_axis_tlast <= 1'b0;
                            output_axis_tuser <= 1'b0;
                            count             <= n;
                        end
                    end
                end
                DISCARD: begin
                    if (accept && input_axis_tlast) begin
                        state <= PASS;
                    end
                end
                default: begin
                    state <= PASS;
                end
            endcase
        end
    end

`ifdef FRAME_LEN_STATS_EN
    logic good_evt;
    logic short_evt;
    logic long_evt;

    assign good_evt  = (state == PASS) & accept &  input_axis_tlast & ~is_short;
    assign short_evt = (state == PASS) & accept &  input_axis_tlast &  is_short;
    assign long_evt  = (state == PASS) & accept & ~input_axis_tlast &  is_max;

    // Saturating frame statistics, updated alongside the status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            good_frame_count  <= '0;
            short_frame_count <= '0;
            long_frame_count  <= '0;
        end else begin
            if (good_evt && (good_frame_count != 16'hFFFF)) begin
                good_frame_count <= good_frame_count + 16'd1;
            end
            if (short_evt && (short_frame_count != 16'hFFFF)) begin
                short_frame_count <= short_frame_count + 16'd1;
            end
            if (long_evt && (long_frame_count != 16'hFFFF)) begin
                long_frame_count <= long_frame_count + 16'd1;
            end
        end
    end
`endif

endmodule
